// File: rtl/menu_pkg.sv
// Shared menu definitions: navigator FSM states, item codes, counter sizing.
package menu_pkg;

  typedef enum logic [1:0] {
    StLocked   = 2'b00,
    StBrowse   = 2'b01,
    StConfirm  = 2'b10,
    StWaitExit = 2'b11
  } menu_state_e;

  // Item codes shared with the state controller and the OLED menu renderer.
  localparam logic [1:0] ITEM_VOLUME  = 2'b00;
  localparam logic [1:0] ITEM_POKEMON = 2'b01;
  localparam logic [1:0] ITEM_FRUIT   = 2'b10;
  localparam logic [1:0] ITEM_POTION  = 2'b11;

  // Counter width for a modulo-max counter, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned max);
    return (max > 1) ? $clog2(max) : 1;
  endfunction

endpackage

// File: rtl/cycle_counter.sv
// Modulo-MAX up counter with synchronous clear; at_max flags the last count.
module cycle_counter
  import menu_pkg::*;
#(
  parameter int unsigned MAX = 2,
  localparam int unsigned W = cnt_width(MAX)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         enable,
  output logic [W-1:0] count,
  output logic         at_max
);

  localparam logic [W-1:0] Last = W'(MAX - 1);

  logic [W-1:0] count_q, count_d;

  // Clear wins over enable; an enabled count at MAX-1 wraps to zero.
  always_comb begin
    at_max  = (count_q == Last);
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = at_max ? '0 : count_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/menu_navigator.sv
// Main-menu cursor on a 2x2 grid plus a fixed-length confirm animation that
// ends in a one-clock confirm pulse for the top-level state controller.
module menu_navigator
  import menu_pkg::*;
#(
  parameter int unsigned CONFIRM_CYCLES = 200,
  parameter int unsigned IDLE_TIMEOUT   = 30000,
  parameter int unsigned BLINK_HALF     = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       menu_active,
  input  logic       btnL,
  input  logic       btnR,
  input  logic       btnU,
  input  logic       btnD,
  input  logic       btnC,
  output logic [1:0] selection,
  output logic       confirm,
  output logic       confirming,
  output logic       blink
);

  menu_state_e state_q, state_d;
  logic [1:0]  selection_q, selection_d;
  logic        confirm_q, confirm_d;
  logic        confirming_q, confirming_d;
  logic        blink_q, blink_d;

  logic conf_clear, conf_en, conf_max;
  logic idle_clear, idle_en, idle_max;
  logic blink_clear, blink_en, blink_max;

  logic [cnt_width(CONFIRM_CYCLES)-1:0] conf_cnt;
  logic [cnt_width(IDLE_TIMEOUT)-1:0]   idle_cnt;
  logic [cnt_width(BLINK_HALF)-1:0]     blink_cnt;

  // Only the wrap flags drive decisions; the raw counts stay observable.
  logic unused_cnt;
  assign unused_cnt = ^{conf_cnt, idle_cnt, blink_cnt};

  cycle_counter #(.MAX(CONFIRM_CYCLES)) u_conf_cnt (
    .clk    (clk),
    .rst    (rst),
    .clear  (conf_clear),
    .enable (conf_en),
    .count  (conf_cnt),
    .at_max (conf_max)
  );

  cycle_counter #(.MAX(IDLE_TIMEOUT)) u_idle_cnt (
    .clk    (clk),
    .rst    (rst),
    .clear  (idle_clear),
    .enable (idle_en),
    .count  (idle_cnt),
    .at_max (idle_max)
  );

  cycle_counter #(.MAX(BLINK_HALF)) u_blink_cnt (
    .clk    (clk),
    .rst    (rst),
    .clear  (blink_clear),
    .enable (blink_en),
    .count  (blink_cnt),
    .at_max (blink_max)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StLocked;
    else     state_q <= state_d;
  end

  // Next state; leaving the menu forces LOCKED from anywhere.
  always_comb begin
    state_d = state_q;
    if (!menu_active) begin
      state_d = StLocked;
    end else begin
      case (state_q)
        StLocked:   state_d = StBrowse;
        StBrowse:   if (btnC) state_d = StConfirm;
        StConfirm:  if (conf_max) state_d = StWaitExit;
        StWaitExit: state_d = StWaitExit;
        default:    state_d = StLocked;
      endcase
    end
  end

  // Next output values and counter controls; C > L/R > U/D priority in BROWSE.
  always_comb begin
    selection_d  = selection_q;
    confirm_d    = 1'b0;
    confirming_d = 1'b0;
    blink_d      = 1'b0;
    conf_clear   = 1'b0;
    conf_en      = 1'b0;
    idle_clear   = 1'b0;
    idle_en      = 1'b0;
    blink_clear  = 1'b0;
    blink_en     = 1'b0;
    if (menu_active) begin
      case (state_q)
        StLocked: begin
          idle_clear  = 1'b1;
          blink_clear = 1'b1;
          blink_d     = 1'b1;
        end
        StBrowse: begin
          if (btnC) begin
            conf_clear   = 1'b1;
            confirming_d = 1'b1;
            blink_d      = 1'b1;
          end else begin
            blink_en = 1'b1;
            blink_d  = blink_max ? ~blink_q : blink_q;
            if (btnL || btnR || btnU || btnD) begin
              selection_d = (btnL || btnR) ? selection_q ^ 2'b01 : selection_q ^ 2'b10;
              idle_clear  = 1'b1;
              blink_clear = 1'b1;
              blink_d     = 1'b1;
            end else begin
              // Idle counter wraps to zero on its own at the timeout.
              idle_en = 1'b1;
              if (idle_max) begin
                selection_d = ITEM_VOLUME;
                blink_clear = 1'b1;
                blink_d     = 1'b1;
              end
            end
          end
        end
        StConfirm: begin
          conf_en = 1'b1;
          if (conf_max) begin
            confirm_d = 1'b1;
          end else begin
            confirming_d = 1'b1;
            blink_d      = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      selection_q  <= ITEM_VOLUME;
      confirm_q    <= 1'b0;
      confirming_q <= 1'b0;
      blink_q      <= 1'b0;
    end else begin
      selection_q  <= selection_d;
      confirm_q    <= confirm_d;
      confirming_q <= confirming_d;
      blink_q      <= blink_d;
    end
  end

  assign selection  = selection_q;
  assign confirm    = confirm_q;
  assign confirming = confirming_q;
  assign blink      = blink_q;

endmodule

// File: tb/tb_menu_navigator.sv
// Self-checking bench for menu_navigator: directed scenarios plus a random run
// compared against a time-based behavioural model.
module tb_menu_navigator;

  localparam int CC = 4;
  localparam int IT = 10;
  localparam int BH = 3;

  // Button vector layout {C, L, R, U, D}.
  localparam logic [4:0] B_N = 5'b00000;
  localparam logic [4:0] B_C = 5'b10000;
  localparam logic [4:0] B_L = 5'b01000;
  localparam logic [4:0] B_R = 5'b00100;
  localparam logic [4:0] B_U = 5'b00010;
  localparam logic [4:0] B_D = 5'b00001;

  localparam int MLocked  = 0;
  localparam int MBrowse  = 1;
  localparam int MConfirm = 2;
  localparam int MWait    = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       menu_active;
  logic       btnL, btnR, btnU, btnD, btnC;
  logic [1:0] selection;
  logic       confirm, confirming, blink;

  int errors = 0;
  int checks = 0;

  // Model: mode, cursor, clocks since last activity, since blink restart,
  // since btnC, and the pending confirm pulse.
  int         m_mode;
  logic [1:0] m_sel;
  int         m_idle, m_bage, m_cage;
  logic       m_confirm;

  menu_navigator #(
    .CONFIRM_CYCLES (CC),
    .IDLE_TIMEOUT   (IT),
    .BLINK_HALF     (BH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .menu_active (menu_active),
    .btnL        (btnL),
    .btnR        (btnR),
    .btnU        (btnU),
    .btnD        (btnD),
    .btnC        (btnC),
    .selection   (selection),
    .confirm     (confirm),
    .confirming  (confirming),
    .blink       (blink)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_mode    = MLocked;
    m_sel     = 2'b00;
    m_idle    = 0;
    m_bage    = 0;
    m_cage    = 0;
    m_confirm = 1'b0;
  endfunction

  function automatic void model_update(input logic a, input logic [4:0] b);
    m_confirm = 1'b0;
    if (!a) begin
      m_mode = MLocked;
      return;
    end
    case (m_mode)
      MLocked: begin
        m_mode = MBrowse;
        m_idle = 0;
        m_bage = 0;
      end
      MBrowse: begin
        if (b[4]) begin
          m_mode = MConfirm;
          m_cage = 0;
        end else if (b[3] || b[2] || b[1] || b[0]) begin
          if (b[3] || b[2]) m_sel[0] = ~m_sel[0];
          else              m_sel[1] = ~m_sel[1];
          m_idle = 0;
          m_bage = 0;
        end else begin
          m_idle++;
          m_bage++;
          if (m_idle == IT) begin
            m_sel  = 2'b00;
            m_idle = 0;
            m_bage = 0;
          end
        end
      end
      MConfirm: begin
        m_cage++;
        if (m_cage == CC) begin
          m_confirm = 1'b1;
          m_mode    = MWait;
        end
      end
      default: ;
    endcase
  endfunction

  function automatic logic exp_blink();
    if (m_mode == MBrowse) return ((m_bage / BH) % 2) == 0;
    return m_mode == MConfirm;
  endfunction

  // Drive one clock of inputs; buttons drop back after the sampling edge.
  task automatic step(input logic a, input logic [4:0] b);
    menu_active = a;
    {btnC, btnL, btnR, btnU, btnD} = b;
    @(posedge clk);
    model_update(a, b);
    #1;
    {btnC, btnL, btnR, btnU, btnD} = B_N;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    menu_active = 1'b0;
    {btnC, btnL, btnR, btnU, btnD} = B_N;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (selection !== 2'b00) begin errors++; $display("FAIL reset selection: got %b want 00", selection); end
    checks++; if (confirm !== 1'b0) begin errors++; $display("FAIL reset confirm: got %b want 0", confirm); end
    checks++; if (confirming !== 1'b0) begin errors++; $display("FAIL reset confirming: got %b want 0", confirming); end
    checks++; if (blink !== 1'b0) begin errors++; $display("FAIL reset blink: got %b want 0", blink); end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_navigation();
    logic [4:0] btn [5] = '{B_R, B_R, B_D, B_U, B_L};
    logic [1:0] exp [5] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
    step(1'b1, B_N);
    checks++; if (blink !== 1'b1) begin errors++; $display("FAIL browse entry blink: got %b want 1", blink); end
    for (int i = 0; i < 5; i++) begin
      step(1'b1, btn[i]);
      checks++;
      if (selection !== exp[i]) begin
        errors++; $display("FAIL nav step %0d: got %b want %b", i, selection, exp[i]);
      end
    end
  endtask

  task automatic test_simultaneous();
    step(1'b1, B_L);
    checks++; if (selection !== 2'b00) begin errors++; $display("FAIL simul pre: got %b want 00", selection); end
    step(1'b1, B_L | B_D);
    checks++; if (selection !== 2'b01) begin errors++; $display("FAIL simul L+D: got %b want 01", selection); end
    step(1'b1, B_C | B_R);
    checks++; if (confirming !== 1'b1) begin errors++; $display("FAIL simul C+R confirming: got %b want 1", confirming); end
    checks++; if (selection !== 2'b01) begin errors++; $display("FAIL simul C+R selection: got %b want 01", selection); end
    repeat (3) step(1'b1, B_N);
    step(1'b1, B_N);
    checks++; if (confirm !== 1'b1) begin errors++; $display("FAIL simul confirm pulse: got %b want 1", confirm); end
    step(1'b0, B_N);
    checks++; if (blink !== 1'b0) begin errors++; $display("FAIL simul locked blink: got %b want 0", blink); end
  endtask

  task automatic test_confirm_timing();
    step(1'b1, B_N);
    step(1'b1, B_R);
    step(1'b1, B_D);
    checks++; if (selection !== 2'b10) begin errors++; $display("FAIL conf setup: got %b want 10", selection); end
    step(1'b1, B_C);
    for (int i = 0; i < CC; i++) begin
      checks++;
      if (confirming !== 1'b1 || confirm !== 1'b0 || selection !== 2'b10) begin
        errors++;
        $display("FAIL conf edge k+%0d: got confirming=%b confirm=%b sel=%b want 1 0 10",
                 i, confirming, confirm, selection);
      end
      if (i < CC - 1) step(1'b1, B_N);
    end
    step(1'b1, B_N);
    checks++;
    if (confirm !== 1'b1 || confirming !== 1'b0 || selection !== 2'b10) begin
      errors++;
      $display("FAIL conf pulse: got confirm=%b confirming=%b sel=%b want 1 0 10",
               confirm, confirming, selection);
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b1, (i == 2) ? B_C : B_N);
      checks++;
      if (confirm !== 1'b0 || blink !== 1'b0) begin
        errors++; $display("FAIL conf after %0d: got confirm=%b blink=%b want 0 0", i, confirm, blink);
      end
    end
    step(1'b0, B_N);
  endtask

  task automatic test_abort();
    step(1'b1, B_N);
    step(1'b1, B_C);
    step(1'b1, B_N);
    step(1'b0, B_N);
    checks++;
    if (confirming !== 1'b0 || blink !== 1'b0 || confirm !== 1'b0) begin
      errors++;
      $display("FAIL abort: got confirming=%b blink=%b confirm=%b want 0 0 0",
               confirming, blink, confirm);
    end
    for (int i = 0; i < 6; i++) begin
      step(1'b0, B_N);
      checks++; if (confirm !== 1'b0) begin errors++; $display("FAIL abort pulse %0d: got %b want 0", i, confirm); end
    end
    step(1'b1, B_N);
    checks++;
    if (selection !== 2'b10 || blink !== 1'b1 || confirming !== 1'b0) begin
      errors++;
      $display("FAIL abort reentry: got sel=%b blink=%b confirming=%b want 10 1 0",
               selection, blink, confirming);
    end
  endtask

  task automatic test_idle_blink();
    logic pat [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    step(1'b1, B_R);
    checks++; if (selection !== 2'b11) begin errors++; $display("FAIL idle setup: got %b want 11", selection); end
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step(1'b1, B_N);
      checks++; if (blink !== pat[i]) begin errors++; $display("FAIL blink %0d: got %b want %b", i, blink, pat[i]); end
    end
    repeat (4) step(1'b1, B_N);
    checks++; if (selection !== 2'b11) begin errors++; $display("FAIL idle at 9: got %b want 11", selection); end
    step(1'b1, B_N);
    checks++;
    if (selection !== 2'b00 || blink !== 1'b1) begin
      errors++; $display("FAIL idle home: got sel=%b blink=%b want 00 1", selection, blink);
    end
    repeat (8) step(1'b1, B_N);
    step(1'b1, B_R);
    repeat (9) step(1'b1, B_N);
    checks++; if (selection !== 2'b01) begin errors++; $display("FAIL idle postponed: got %b want 01", selection); end
    step(1'b1, B_N);
    checks++; if (selection !== 2'b00) begin errors++; $display("FAIL idle late home: got %b want 00", selection); end
  endtask

  task automatic test_reset_async();
    step(1'b1, B_C);
    step(1'b1, B_N);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (confirming !== 1'b0 || blink !== 1'b0 || confirm !== 1'b0 || selection !== 2'b00) begin
      errors++;
      $display("FAIL async rst confirm: got confirming=%b blink=%b confirm=%b sel=%b want 0 0 0 00",
               confirming, blink, confirm, selection);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    step(1'b1, B_N);
    checks++;
    if (confirming !== 1'b0 || blink !== 1'b1) begin
      errors++; $display("FAIL rst relock: got confirming=%b blink=%b want 0 1", confirming, blink);
    end
    step(1'b1, B_R);
    step(1'b1, B_C);
    repeat (CC) step(1'b1, B_N);
    checks++; if (confirm !== 1'b1) begin errors++; $display("FAIL rst wait pulse: got %b want 1", confirm); end
    step(1'b1, B_N);
    #2 rst = 1'b1;
    #1;
    checks++; if (selection !== 2'b00) begin errors++; $display("FAIL async rst wait sel: got %b want 00", selection); end
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    step(1'b1, B_N);
    checks++; if (blink !== 1'b1) begin errors++; $display("FAIL rst wait relock: got blink=%b want 1", blink); end
  endtask

  task automatic test_random();
    logic       a;
    logic [4:0] b;
    for (int i = 0; i < 800; i++) begin
      a = ($urandom_range(0, 19) != 0);
      for (int j = 0; j < 5; j++) b[j] = ($urandom_range(0, 5) == 0);
      step(a, b);
      checks++; if (selection !== m_sel) begin errors++; $display("FAIL rand sel @%0d: got %b want %b", i, selection, m_sel); end
      checks++; if (confirm !== m_confirm) begin errors++; $display("FAIL rand confirm @%0d: got %b want %b", i, confirm, m_confirm); end
      checks++;
      if (confirming !== (m_mode == MConfirm)) begin
        errors++; $display("FAIL rand confirming @%0d: got %b want %b", i, confirming, m_mode == MConfirm);
      end
      checks++; if (blink !== exp_blink()) begin errors++; $display("FAIL rand blink @%0d: got %b want %b", i, blink, exp_blink()); end
    end
  endtask

  initial begin
    test_reset();
    test_navigation();
    test_simultaneous();
    test_confirm_timing();
    test_abort();
    test_idle_blink();
    test_reset_async();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
